lisa_qspi_sram_target: RTL and testbench

// - Synthesizable QSPI SRAM responder: the target end of the lisa QSPI flash/PSRAM interface.
// - Oversamples ce_n/sclk/dio on the system clock; decodes single-bit commands, 24-bit address and data.
// - Serves an internal byte array; used as an on-FPGA PSRAM stand-in and as a bench responder for the QSPI master.

---
 rtl/lisa_qspi_sram_target_if.sv | 14 +
 rtl/lisa_qspi_sram_target.sv | 214 +++++++++++++++++++++
 tb/tb_lisa_qspi_sram_target.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lisa_qspi_sram_target_if.sv
// Bus bundle between a lisa QSPI master and the SRAM target: chip select, clock and the four DQ lanes.
// The master modport drives ce_n/sclk/dio_in; the slave modport drives everything the target returns.
interface lisa_qspi_sram_target_if;
    logic       ce_n;
    logic       sclk;
    logic [3:0] dio_in;
    logic [3:0] dio_out;
    logic [3:0] dio_oe;
    logic       busy;
    logic       cmd_err;

    modport master (output ce_n, sclk, dio_in, input dio_out, dio_oe, busy, cmd_err);
    modport slave  (input ce_n, sclk, dio_in, output dio_out, dio_oe, busy, cmd_err);
endinterface

// File: rtl/lisa_qspi_sram_target.sv
// QSPI SRAM responder: oversamples ce_n/sclk/dio on clk and serves an internal byte array.
// Quad commands 0x38/0xEB are only decoded when LISA_QSPI_TARGET_QUAD_EN is defined.
module lisa_qspi_sram_target #(
    parameter int ADDR_W       = 10,
    parameter int DUMMY_CYCLES = 6
) (
    input logic                    clk,
    input logic                    rst_n,
    lisa_qspi_sram_target_if.slave bus
);
    // state    | meaning
    // S_IDLE   | deselected, waiting for ce_n fall
    // S_CMD    | shifting in the command byte on DQ0
    // S_ADDR   | shifting in the 24-bit address (DQ0, or DQ[3:0] for quad)
    // S_DUMMY  | fast-read dummy cycles
    // S_WDATA  | receiving write bytes
    // S_RDATA  | driving read bytes
    // S_IGNORE | unsupported command, idle until deselect
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_IGNORE
    } state_t;

    logic [1:0]        r_ce_sync;
    logic [1:0]        r_sclk_sync;
    logic [3:0]        r_dio_s1;
    logic [3:0]        r_dio_s2;
    logic              r_ce_d;
    logic              r_sclk_d;
    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [6:0]        r_sh;
    logic [7:0]        r_cmd;
    logic              r_quad;
    logic [ADDR_W-1:0] r_addr;
    logic [6:0]        r_wsh;
    logic [3:0]        r_dout;
    logic [3:0]        r_oe;
    logic              r_busy;
    logic              r_cmd_err;
    logic [7:0]        r_mem [2**ADDR_W];

    logic              w_ce;
    logic              w_sclk;
    logic [3:0]        w_dio;
    logic              w_rise;
    logic              w_fall;
    logic [7:0]        w_cmd_byte;
    logic [7:0]        w_wbyte;
    logic [7:0]        w_rbyte;
    logic [7:0]        w_byte_top;
    logic [ADDR_W-1:0] w_addr_shift;
    logic              w_is_write;
    logic              w_is_fast;
    logic              w_we;

    assign w_ce         = r_ce_sync[1];
    assign w_sclk       = r_sclk_sync[1];
    assign w_dio        = r_dio_s2;
    assign w_rise       = w_sclk & ~r_sclk_d;
    assign w_fall       = ~w_sclk & r_sclk_d;
    assign w_cmd_byte   = {r_sh, w_dio[0]};
    assign w_wbyte      = r_quad ? {r_wsh[3:0], w_dio} : {r_wsh, w_dio[0]};
    assign w_rbyte      = r_mem[r_addr];
    assign w_byte_top   = r_quad ? 8'd1 : 8'd7;
    assign w_addr_shift = r_quad ? {r_addr[ADDR_W-5:0], w_dio} : {r_addr[ADDR_W-2:0], w_dio[0]};
    assign w_is_write   = (r_cmd == 8'h02) || (r_cmd == 8'h38);
    assign w_is_fast    = (r_cmd == 8'h0B) || (r_cmd == 8'hEB);
    assign w_we         = (r_state == S_WDATA) && w_rise && !w_ce && (r_cnt == 8'd0);

    assign bus.dio_out  = r_dout;
    assign bus.dio_oe   = r_oe;
    assign bus.busy     = r_busy;
    assign bus.cmd_err  = r_cmd_err;

    // All three inputs share the same two-flop delay so sampled data stays aligned with sclk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce_sync   <= 2'b11;
            r_sclk_sync <= 2'b00;
            r_dio_s1    <= '0;
            r_dio_s2    <= '0;
            r_ce_d      <= 1'b1;
            r_sclk_d    <= 1'b0;
        end else begin
            r_ce_sync   <= {r_ce_sync[0], bus.ce_n};
            r_sclk_sync <= {r_sclk_sync[0], bus.sclk};
            r_dio_s1    <= bus.dio_in;
            r_dio_s2    <= r_dio_s1;
            r_ce_d      <= w_ce;
            r_sclk_d    <= w_sclk;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_addr] <= w_wbyte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_cmd     <= '0;
            r_quad    <= 1'b0;
            r_addr    <= '0;
            r_wsh     <= '0;
            r_dout    <= '0;
            r_oe      <= '0;
            r_busy    <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            r_busy    <= ~w_ce;
            // Deselect wins over any sclk edge seen in the same cycle.
            if (w_ce) begin
                r_state <= S_IDLE;
                r_oe    <= '0;
                r_dout  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_ce_d) begin
                            r_state <= S_CMD;
                            r_cnt   <= 8'd7;
                        end
                    end
                    S_CMD: begin
                        if (w_rise) begin
                            r_sh <= w_cmd_byte[6:0];
                            if (r_cnt == 8'd0) begin
                                r_cmd <= w_cmd_byte;
                                case (w_cmd_byte)
                                    8'h02, 8'h03, 8'h0B: begin
                                        r_state <= S_ADDR;
                                        r_quad  <= 1'b0;
                                        r_cnt   <= 8'd23;
                                    end
`ifdef LISA_QSPI_TARGET_QUAD_EN
                                    8'h38, 8'hEB: begin
                                        r_state <= S_ADDR;
                                        r_quad  <= 1'b1;
                                        r_cnt   <= 8'd5;
                                    end
`endif
                                    default: begin
                                        r_state   <= S_IGNORE;
                                        r_cmd_err <= 1'b1;
                                    end
                                endcase
                            end else begin
                                r_cnt <= r_cnt - 8'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_rise) begin
                            r_addr <= w_addr_shift;
                            if (r_cnt == 8'd0) begin
                                if (w_is_write) begin
                                    r_state <= S_WDATA;
                                    r_cnt   <= w_byte_top;
                                end else if (w_is_fast && (DUMMY_CYCLES > 0)) begin
                                    r_state <= S_DUMMY;
                                    r_cnt   <= 8'(DUMMY_CYCLES - 1);
                                end else begin
                                    r_state <= S_RDATA;
                                    r_cnt   <= w_byte_top;
                                end
                            end else begin
                                r_cnt <= r_cnt - 8'd1;
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (w_rise) begin
                            if (r_cnt == 8'd0) begin
                                r_state <= S_RDATA;
                                r_cnt   <= w_byte_top;
                            end else begin
                                r_cnt <= r_cnt - 8'd1;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_rise) begin
                            r_wsh <= w_wbyte[6:0];
                            if (r_cnt == 8'd0) begin
                                r_addr <= r_addr + 1'b1;
                                r_cnt  <= w_byte_top;
                            end else begin
                                r_cnt <= r_cnt - 8'd1;
                            end
                        end
                    end
                    S_RDATA: begin
                        // r_cnt doubles as the bit (or nibble) index of the byte being driven.
                        if (w_fall) begin
                            r_oe <= r_quad ? 4'hF : 4'b0010;
                            if (r_quad) r_dout <= r_cnt[0] ? w_rbyte[7:4] : w_rbyte[3:0];
                            else        r_dout <= {2'b00, w_rbyte[r_cnt[2:0]], 1'b0};
                            if (r_cnt == 8'd0) begin
                                r_addr <= r_addr + 1'b1;
                                r_cnt  <= w_byte_top;
                            end else begin
                                r_cnt <= r_cnt - 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lisa_qspi_sram_target.sv
// Self-checking bench for lisa_qspi_sram_target: directed vector table, hand-written corner sequences,
// and random bursts checked against a byte-array model (quad sequence when LISA_QSPI_TARGET_QUAD_EN).
`timescale 1ns/1ps
module tb_lisa_qspi_sram_target;
    localparam int ADDR_W = 10;
    localparam int DUMMY  = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    lisa_qspi_sram_target_if bus();

    lisa_qspi_sram_target #(.ADDR_W(ADDR_W), .DUMMY_CYCLES(DUMMY)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         err_cnt = 0;
    int         oe_bad;
    int         dummy_oe_bad;
    int         busy_bad;
    logic [7:0] model [DEPTH];
    logic [7:0] wbuf [64];
    logic [7:0] rbuf [64];

    always @(negedge clk) if (bus.cmd_err === 1'b1) err_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One sclk period: present v during the low phase, sample outputs just before the rise.
    task automatic xfer(input logic [3:0] v, output logic [3:0] d, output logic [3:0] oe);
        bus.dio_in = v;
        #40;
        d  = bus.dio_out;
        oe = bus.dio_oe;
        if (bus.busy !== 1'b1) busy_bad++;
        bus.sclk = 1'b1;
        #40;
        bus.sclk = 1'b0;
    endtask

    task automatic send_ser(input logic [31:0] val, input int nbits);
        logic [3:0] d, oe;
        for (int i = nbits - 1; i >= 0; i--) xfer({3'b000, val[i]}, d, oe);
    endtask

    task automatic begin_tx;
        bus.ce_n = 1'b0;
        #10;
    endtask

    task automatic end_tx;
        #40;
        bus.ce_n = 1'b1;
        #80;
    endtask

    task automatic send_addr(input logic [23:0] addr, input bit quad);
        logic [3:0] d, oe;
        if (quad) for (int i = 5; i >= 0; i--) xfer(addr[i*4 +: 4], d, oe);
        else send_ser({8'h00, addr}, 24);
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [23:0] addr, input int n, input bit quad);
        logic [3:0] d, oe;
        begin_tx;
        send_ser({24'h0, cmd}, 8);
        send_addr(addr, quad);
        for (int b = 0; b < n; b++) begin
            if (quad) begin
                xfer(wbuf[b][7:4], d, oe);
                xfer(wbuf[b][3:0], d, oe);
            end else begin
                send_ser({24'h0, wbuf[b]}, 8);
            end
        end
        end_tx;
        for (int b = 0; b < n; b++) model[(int'(addr[ADDR_W-1:0]) + b) % DEPTH] = wbuf[b];
    endtask

    task automatic do_read(input logic [7:0] cmd, input logic [23:0] addr, input int n, input bit quad);
        logic [3:0] d, oe;
        bit         fast;
        fast = (cmd == 8'h0B) || (cmd == 8'hEB);
        oe_bad = 0;
        dummy_oe_bad = 0;
        begin_tx;
        send_ser({24'h0, cmd}, 8);
        send_addr(addr, quad);
        if (fast) for (int k = 0; k < DUMMY; k++) begin
            xfer(4'($urandom), d, oe);
            if (oe !== 4'h0) dummy_oe_bad++;
        end
        for (int b = 0; b < n; b++) begin
            if (quad) begin
                xfer(4'h0, d, oe);
                rbuf[b][7:4] = d;
                if (oe !== 4'hF) oe_bad++;
                xfer(4'h0, d, oe);
                rbuf[b][3:0] = d;
                if (oe !== 4'hF) oe_bad++;
            end else begin
                for (int i = 7; i >= 0; i--) begin
                    xfer(4'h0, d, oe);
                    rbuf[b][i] = d[1];
                    if (oe !== 4'b0010) oe_bad++;
                end
            end
        end
        end_tx;
    endtask

    typedef struct {
        logic [7:0]  wcmd;
        logic [23:0] waddr;
        int          wn;
        logic [7:0]  w0, w1;
        logic [7:0]  rcmd;
        logic [23:0] raddr;
        logic [7:0]  e0, e1;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [3:0]  d, oe;
        logic [13:0] hi;
        logic [23:0] a;
        logic [7:0]  rc;
        int          n, off, e_snap;

        bus.ce_n = 1'b1;
        bus.sclk = 1'b0;
        bus.dio_in = 4'h0;
        busy_bad = 0;
        #30;
        chk("rst_oe", {28'h0, bus.dio_oe}, 0);
        chk("rst_out", {28'h0, bus.dio_out}, 0);
        rst_n = 1'b1;
        #40;
        chk("idle_busy", {31'h0, bus.busy}, 0);
        chk("idle_err", {31'h0, bus.cmd_err}, 0);

        vt[0] = '{8'h02, 24'h000010, 2, 8'hA5, 8'h3C, 8'h03, 24'h000010, 8'hA5, 8'h3C};
        vt[1] = '{8'h02, 24'h000000, 0, 8'h00, 8'h00, 8'h0B, 24'h000010, 8'hA5, 8'h3C};
        vt[2] = '{8'h02, 24'h000001, 2, 8'h77, 8'h88, 8'h03, 24'h000001, 8'h77, 8'h88};
        vt[3] = '{8'h02, 24'h0003FF, 2, 8'h11, 8'h22, 8'h03, 24'h000000, 8'h22, 8'h77};
        vt[4] = '{8'h02, 24'h000000, 0, 8'h00, 8'h00, 8'h0B, 24'hFFF3FF, 8'h11, 8'h22};
        vt[5] = '{8'h02, 24'hFFFC20, 2, 8'h00, 8'h66, 8'h03, 24'h000020, 8'h00, 8'h66};

        e_snap = err_cnt;
        for (int i = 0; i < 6; i++) begin
            if (vt[i].wn > 0) begin
                wbuf[0] = vt[i].w0;
                wbuf[1] = vt[i].w1;
                do_write(vt[i].wcmd, vt[i].waddr, vt[i].wn, 1'b0);
            end
            do_read(vt[i].rcmd, vt[i].raddr, 2, 1'b0);
            chk($sformatf("vec%0d_b0", i), {24'h0, rbuf[0]}, {24'h0, vt[i].e0});
            chk($sformatf("vec%0d_b1", i), {24'h0, rbuf[1]}, {24'h0, vt[i].e1});
            chk($sformatf("vec%0d_oe", i), oe_bad, 0);
            chk($sformatf("vec%0d_dummy_oe", i), dummy_oe_bad, 0);
        end
        chk("no_err_valid_cmds", err_cnt - e_snap, 0);
        chk("busy_during_tx", busy_bad, 0);

        // Partial second byte is dropped on deselect; 0x21 keeps its prior 0x66.
        begin_tx;
        send_ser(32'h02, 8);
        send_addr(24'h000020, 1'b0);
        send_ser(32'h55, 8);
        send_ser(32'hA, 4);
        end_tx;
        do_read(8'h03, 24'h000020, 2, 1'b0);
        chk("partial_b0", {24'h0, rbuf[0]}, 32'h55);
        chk("partial_b1", {24'h0, rbuf[1]}, 32'h66);

        e_snap = err_cnt;
        oe_bad = 0;
        begin_tx;
        send_ser(32'h9F, 8);
        for (int k = 0; k < 16; k++) begin
            xfer(4'($urandom), d, oe);
            if (oe !== 4'h0) oe_bad++;
        end
        chk("unk_busy_hi", {31'h0, bus.busy}, 1);
        end_tx;
        chk("unk_err_pulses", err_cnt - e_snap, 1);
        chk("unk_oe_off", oe_bad, 0);
        chk("unk_busy_lo", {31'h0, bus.busy}, 0);

        e_snap = err_cnt;
        begin_tx;
        send_ser(32'h9, 4);
        end_tx;
        chk("abort_cmd_no_err", err_cnt - e_snap, 0);

`ifdef LISA_QSPI_TARGET_QUAD_EN
        wbuf[0] = 8'h5A;
        do_write(8'h38, 24'h000040, 1, 1'b1);
        do_read(8'hEB, 24'h000040, 1, 1'b1);
        chk("quad_hi_nib", {28'h0, rbuf[0][7:4]}, 32'h5);
        chk("quad_lo_nib", {28'h0, rbuf[0][3:0]}, 32'hA);
        chk("quad_oe", oe_bad, 0);
        chk("quad_dummy_oe", dummy_oe_bad, 0);
`else
        e_snap = err_cnt;
        begin_tx;
        send_ser(32'h38, 8);
        send_ser(32'h0, 8);
        end_tx;
        begin_tx;
        send_ser(32'hEB, 8);
        oe_bad = 0;
        for (int k = 0; k < 8; k++) begin
            xfer(4'h0, d, oe);
            if (oe !== 4'h0) oe_bad++;
        end
        end_tx;
        chk("quad_off_err", err_cnt - e_snap, 2);
        chk("quad_off_oe", oe_bad, 0);
`endif

        // Async reset in the middle of a read must drop the drivers immediately.
        begin_tx;
        send_ser(32'h03, 8);
        send_addr(24'h000010, 1'b0);
        for (int k = 0; k < 3; k++) xfer(4'h0, d, oe);
        chk("pre_rst_oe", {28'h0, oe}, 32'h2);
        #30;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", {28'h0, bus.dio_oe}, 0);
        chk("rst_mid_busy", {31'h0, bus.busy}, 0);
        #9;
        bus.ce_n = 1'b1;
        #20;
        rst_n = 1'b1;
        #40;
        do_read(8'h03, 24'h000010, 2, 1'b0);
        chk("mem_kept_b0", {24'h0, rbuf[0]}, 32'hA5);
        chk("mem_kept_b1", {24'h0, rbuf[1]}, 32'h3C);

        for (int i = 0; i < 64; i++) wbuf[i] = 8'($urandom);
        do_write(8'h02, 24'h000100, 64, 1'b0);
        for (int k = 0; k < 16; k++) begin
            n   = $urandom_range(1, 4);
            off = $urandom_range(0, 64 - n);
            hi  = 14'($urandom);
            a   = {hi, 10'(256 + off)};
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < n; b++) wbuf[b] = 8'($urandom);
                do_write(8'h02, a, n, 1'b0);
            end else begin
                rc = ($urandom_range(0, 1) == 1) ? 8'h0B : 8'h03;
                do_read(rc, a, n, 1'b0);
                for (int b = 0; b < n; b++)
                    chk($sformatf("rnd%0d_b%0d", k, b), {24'h0, rbuf[b]}, {24'h0, model[256 + off + b]});
                chk($sformatf("rnd%0d_oe", k), oe_bad + dummy_oe_bad, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
